board_ctrl: RTL and testbench

//  Game sequencer owning the 20x10 playfield register consumed by the DVI renderer.

---
 rtl/board_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_board_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_ctrl.sv
// board_ctrl: game sequencer owning the 20x10 playfield read by the DVI renderer.
// Spawns a 1-cell piece, applies frame-timed gravity and pulse moves, locks it,
// clears full rows and tracks score / game-over.
// Build option GRAVITY_SPEEDUP_EN: gravity interval shrinks by 2 frames every
// 4 cleared rows (floor 4 frames). Undefined: fixed interval of GRAV_FRAMES.
module board_ctrl #(
  parameter int unsigned ROWS        = 20,
  parameter int unsigned COLS        = 10,
  parameter int unsigned GRAV_FRAMES = 30,
  parameter int unsigned SPAWN_COL   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_frame_start,
  input  logic        i_pls_w,
  input  logic        i_pls_e,
  input  logic        i_pls_s,
  input  logic        i_pls_c,
  input  logic        i_pls_n,
  input  logic [4:0]  i_rd_row,
  input  logic [3:0]  i_rd_col,
  output logic [3:0]  o_rd_cell,
  output logic        o_busy,
  output logic        o_game_over,
  output logic [15:0] o_score
);

  localparam int unsigned CELL_W  = 4;
  localparam int unsigned ROW_W   = COLS * CELL_W;
  localparam int unsigned BOARD_W = ROWS * ROW_W;
  localparam int unsigned IDX_W   = $clog2(BOARD_W);

  typedef enum logic [2:0] {
    ST_SPAWN = 3'd0,
    ST_FALL  = 3'd1,
    ST_DROP  = 3'd2,
    ST_LOCK  = 3'd3,
    ST_SCAN  = 3'd4,
    ST_SHIFT = 3'd5,
    ST_OVER  = 3'd6
  } state_e;

  state_e             state_q, state_d;
  logic [BOARD_W-1:0] board_q, board_d;
  logic [4:0]         row_q, row_d;
  logic [3:0]         col_q, col_d;
  logic [3:0]         color_q, color_d;
  logic [2:0]         color_cnt_q, color_cnt_d;
  logic [5:0]         grav_cnt_q, grav_cnt_d;
  logic               grav_pend_q, grav_pend_d;
  logic [4:0]         scan_q, scan_d;
  logic [15:0]        score_q, score_d;
  logic [3:0]         rd_cell_q, rd_cell_d;
  logic               busy_q, busy_d;
  logic               over_q, over_d;

  logic       blocked_c, row_full_c, spawn_hit_c;
  logic       east_ok_c, west_ok_c;
  logic       grav_hit_c, grav_req_c;
  logic [6:0] interval_c, grav_inc_c;

  // Bit offset of cell (r,c) inside the flat board vector
  function automatic logic [IDX_W-1:0] cell_idx(input logic [4:0] r, input logic [3:0] c);
    return IDX_W'((32'(r) * COLS + 32'(c)) * CELL_W);
  endfunction

`ifdef GRAVITY_SPEEDUP_EN
  logic [15:0] speed_dec_c;

  // Gravity interval shortened by 2 frames per 4 cleared rows, never below 4
  always_comb begin
    speed_dec_c = {1'b0, score_q[15:2], 1'b0};
    if (32'(speed_dec_c) + 32'd4 >= GRAV_FRAMES) interval_c = 7'd4;
    else                                          interval_c = 7'(GRAV_FRAMES - 32'(speed_dec_c));
  end
`else
  // Fixed gravity interval
  always_comb begin
    interval_c = 7'(GRAV_FRAMES);
  end
`endif

  // Board-derived conditions and gravity timing decode
  always_comb begin
    blocked_c = 1'b1;
    if (32'(row_q) < ROWS - 1)
      blocked_c = (board_q[cell_idx(row_q + 5'd1, col_q) +: CELL_W] != '0);
    east_ok_c = 1'b0;
    if (32'(col_q) < COLS - 1)
      east_ok_c = (board_q[cell_idx(row_q, col_q + 4'd1) +: CELL_W] == '0);
    west_ok_c = 1'b0;
    if (col_q != 4'd0)
      west_ok_c = (board_q[cell_idx(row_q, col_q - 4'd1) +: CELL_W] == '0);
    row_full_c = 1'b1;
    for (int unsigned c = 0; c < COLS; c++)
      if (board_q[cell_idx(scan_q, 4'(c)) +: CELL_W] == '0) row_full_c = 1'b0;
    spawn_hit_c = (board_q[cell_idx(5'd0, 4'(SPAWN_COL)) +: CELL_W] != '0);
    grav_inc_c  = {1'b0, grav_cnt_q} + 7'd1;
    grav_hit_c  = i_frame_start && (grav_inc_c >= interval_c);
    grav_req_c  = grav_hit_c || grav_pend_q;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_SPAWN;
    else        state_q <= state_d;
  end

  // Next-state logic; restart wins in every state
  always_comb begin
    state_d = state_q;
    if (i_pls_n) begin
      state_d = ST_SPAWN;
    end else begin
      case (state_q)
        ST_SPAWN: state_d = spawn_hit_c ? ST_OVER : ST_FALL;
        ST_FALL: begin
          if (i_pls_c)                          state_d = ST_DROP;
          else if (i_pls_s)                     state_d = blocked_c ? ST_LOCK : ST_FALL;
          else if (i_pls_e || i_pls_w)          state_d = ST_FALL;
          else if (grav_req_c && blocked_c)     state_d = ST_LOCK;
        end
        ST_DROP:  if (blocked_c) state_d = ST_LOCK;
        ST_LOCK:  state_d = ST_SCAN;
        ST_SCAN: begin
          if (row_full_c)          state_d = ST_SHIFT;
          else if (scan_q == 5'd0) state_d = ST_SPAWN;
        end
        ST_SHIFT: state_d = ST_SCAN;
        ST_OVER:  state_d = ST_OVER;
        default:  state_d = ST_SPAWN;
      endcase
    end
  end

  // Datapath and registered output next values
  always_comb begin
    board_d     = board_q;
    row_d       = row_q;
    col_d       = col_q;
    color_d     = color_q;
    color_cnt_d = color_cnt_q;
    grav_cnt_d  = grav_cnt_q;
    grav_pend_d = 1'b0;
    scan_d      = scan_q;
    score_d     = score_q;

    if (i_pls_n) begin
      board_d    = '0;
      score_d    = '0;
      grav_cnt_d = '0;
      row_d      = '0;
      col_d      = 4'(SPAWN_COL);
      scan_d     = 5'(ROWS - 1);
    end else begin
      case (state_q)
        ST_SPAWN: begin
          row_d       = '0;
          col_d       = 4'(SPAWN_COL);
          color_d     = {1'b0, color_cnt_q};
          color_cnt_d = (color_cnt_q == 3'd7) ? 3'd1 : color_cnt_q + 3'd1;
        end
        ST_FALL: begin
          if (i_frame_start) grav_cnt_d = grav_hit_c ? 6'd0 : grav_cnt_q + 6'd1;
          if (i_pls_c) begin
            grav_cnt_d = '0;
          end else if (i_pls_s) begin
            grav_cnt_d  = '0;
            grav_pend_d = grav_req_c;
            if (!blocked_c) row_d = row_q + 5'd1;
          end else if (i_pls_e) begin
            grav_pend_d = grav_req_c;
            if (east_ok_c) col_d = col_q + 4'd1;
          end else if (i_pls_w) begin
            grav_pend_d = grav_req_c;
            if (west_ok_c) col_d = col_q - 4'd1;
          end else if (grav_req_c && !blocked_c) begin
            row_d = row_q + 5'd1;
          end
        end
        ST_DROP: if (!blocked_c) row_d = row_q + 5'd1;
        ST_LOCK: begin
          board_d[cell_idx(row_q, col_q) +: CELL_W] = color_q;
          scan_d = 5'(ROWS - 1);
        end
        ST_SCAN: if (!row_full_c && scan_q != 5'd0) scan_d = scan_q - 5'd1;
        ST_SHIFT: begin
          for (int unsigned r = 1; r < ROWS; r++)
            if (5'(r) <= scan_q)
              board_d[IDX_W'(r * ROW_W) +: ROW_W] = board_q[IDX_W'((r - 1) * ROW_W) +: ROW_W];
          board_d[ROW_W-1:0] = '0;
          score_d = (score_q == 16'hFFFF) ? score_q : score_q + 16'd1;
        end
        default: ;
      endcase
    end

    rd_cell_d = '0;
    if (32'(i_rd_row) < ROWS && 32'(i_rd_col) < COLS) begin
      rd_cell_d = board_q[cell_idx(i_rd_row, i_rd_col) +: CELL_W];
      if ((state_q == ST_FALL || state_q == ST_DROP) && i_rd_row == row_q && i_rd_col == col_q)
        rd_cell_d = color_q;
    end
    busy_d = (state_d != ST_FALL);
    over_d = (state_d == ST_OVER);
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      board_q     <= '0;
      row_q       <= '0;
      col_q       <= 4'(SPAWN_COL);
      color_q     <= '0;
      color_cnt_q <= 3'd1;
      grav_cnt_q  <= '0;
      grav_pend_q <= 1'b0;
      scan_q      <= 5'(ROWS - 1);
      score_q     <= '0;
      rd_cell_q   <= '0;
      busy_q      <= 1'b1;
      over_q      <= 1'b0;
    end else begin
      board_q     <= board_d;
      row_q       <= row_d;
      col_q       <= col_d;
      color_q     <= color_d;
      color_cnt_q <= color_cnt_d;
      grav_cnt_q  <= grav_cnt_d;
      grav_pend_q <= grav_pend_d;
      scan_q      <= scan_d;
      score_q     <= score_d;
      rd_cell_q   <= rd_cell_d;
      busy_q      <= busy_d;
      over_q      <= over_d;
    end
  end

  assign o_rd_cell   = rd_cell_q;
  assign o_busy      = busy_q;
  assign o_game_over = over_q;
  assign o_score     = score_q;

endmodule

// File: tb/tb_board_ctrl.sv
// tb_board_ctrl: randomized gameplay against a playfield reference model,
// expected outputs queued per cycle and compared by an independent monitor.
`timescale 1ns/1ps
module tb_board_ctrl;

  localparam int ROWS = 20;
  localparam int COLS = 10;
  localparam int GRAV = 30;
  localparam int SPAWN_COL = 4;

  localparam int P_SPAWN = 0, P_FALL = 1, P_DROP = 2, P_LOCK = 3,
                 P_SCAN = 4, P_SHIFT = 5, P_OVER = 6;
  localparam int M_FRAMES = 0, M_SWEEP = 1, M_PLAY = 2, M_STACK = 3, M_NPULSE = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_frame_start, i_pls_w, i_pls_e, i_pls_s, i_pls_c, i_pls_n;
  logic [4:0] i_rd_row;
  logic [3:0] i_rd_col;
  logic [3:0] o_rd_cell;
  logic o_busy, o_game_over;
  logic [15:0] o_score;

  board_ctrl dut (
    .clk(clk), .rst_n(rst_n), .i_frame_start(i_frame_start),
    .i_pls_w(i_pls_w), .i_pls_e(i_pls_e), .i_pls_s(i_pls_s),
    .i_pls_c(i_pls_c), .i_pls_n(i_pls_n),
    .i_rd_row(i_rd_row), .i_rd_col(i_rd_col), .o_rd_cell(o_rd_cell),
    .o_busy(o_busy), .o_game_over(o_game_over), .o_score(o_score)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int rd;
    int busy;
    int over;
    int score;
  } exp_t;

  exp_t sb[$];
  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  int mb[ROWS][COLS];
  int m_phase, m_row, m_col, m_color, m_next_color;
  int m_gcnt, m_pend, m_scan, m_score;
  int target = SPAWN_COL;
  int sweep_idx = 0;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
  endtask

  function automatic int m_interval();
`ifdef GRAVITY_SPEEDUP_EN
    int v;
    v = GRAV - 2 * (m_score / 4);
    return (v < 4) ? 4 : v;
`else
    return GRAV;
`endif
  endfunction

  task automatic model_reset(input bit hard);
    foreach (mb[r, c]) mb[r][c] = 0;
    m_score = 0; m_gcnt = 0; m_pend = 0;
    m_row = 0; m_col = SPAWN_COL; m_scan = ROWS - 1;
    m_phase = P_SPAWN;
    if (hard) begin
      m_next_color = 1;
      m_color = 0;
    end
  endtask

  function automatic int model_read(input int r, input int c);
    if (r >= ROWS || c >= COLS) return 0;
    if ((m_phase == P_FALL || m_phase == P_DROP) && r == m_row && c == m_col) return m_color;
    return mb[r][c];
  endfunction

  function automatic bit model_blocked();
    if (m_row == ROWS - 1) return 1'b1;
    return mb[m_row + 1][m_col] != 0;
  endfunction

  task automatic model_step(input bit f, input bit n, input bit c, input bit s,
                            input bit e, input bit w);
    bit hit, greq, full;
    if (n) begin
      model_reset(1'b0);
      return;
    end
    case (m_phase)
      P_SPAWN: begin
        m_row = 0; m_col = SPAWN_COL; m_pend = 0;
        m_color = m_next_color;
        m_next_color = (m_next_color % 7) + 1;
        m_phase = (mb[0][SPAWN_COL] != 0) ? P_OVER : P_FALL;
      end
      P_FALL: begin
        hit = 1'b0;
        if (f) begin
          m_gcnt++;
          if (m_gcnt >= m_interval()) begin hit = 1'b1; m_gcnt = 0; end
        end
        greq = hit || (m_pend != 0);
        m_pend = 0;
        if (c) begin
          m_gcnt = 0; m_phase = P_DROP;
        end else if (s) begin
          m_gcnt = 0; m_pend = greq;
          if (model_blocked()) m_phase = P_LOCK; else m_row++;
        end else if (e) begin
          m_pend = greq;
          if (m_col < COLS - 1 && mb[m_row][m_col + 1] == 0) m_col++;
        end else if (w) begin
          m_pend = greq;
          if (m_col > 0 && mb[m_row][m_col - 1] == 0) m_col--;
        end else if (greq) begin
          if (model_blocked()) m_phase = P_LOCK; else m_row++;
        end
      end
      P_DROP: if (model_blocked()) m_phase = P_LOCK; else m_row++;
      P_LOCK: begin
        mb[m_row][m_col] = m_color;
        m_scan = ROWS - 1;
        m_phase = P_SCAN;
      end
      P_SCAN: begin
        full = 1'b1;
        for (int k = 0; k < COLS; k++) if (mb[m_scan][k] == 0) full = 1'b0;
        if (full) m_phase = P_SHIFT;
        else if (m_scan == 0) m_phase = P_SPAWN;
        else m_scan--;
      end
      P_SHIFT: begin
        for (int r = m_scan; r >= 1; r--)
          for (int k = 0; k < COLS; k++) mb[r][k] = mb[r - 1][k];
        for (int k = 0; k < COLS; k++) mb[0][k] = 0;
        if (m_score < 65535) m_score++;
        m_phase = P_SCAN;
      end
      default: ;
    endcase
  endtask

  // Column whose topmost filled cell is deepest (emptiest column)
  function automatic int lowest_col();
    int best, best_d, d;
    best = 0; best_d = -1;
    for (int k = 0; k < COLS; k++) begin
      d = ROWS;
      for (int r = ROWS - 1; r >= 0; r--) if (mb[r][k] != 0) d = r;
      if (d > best_d) begin best_d = d; best = k; end
    end
    return best;
  endfunction

  // ---------------- driver: called at posedge+1, returns at next posedge+1 ----------------
  task automatic drive_cycle(input int mode);
    bit f, n, c, s, e, w;
    int rr, rc;
    exp_t x;
    f = 0; n = 0; c = 0; s = 0; e = 0; w = 0;
    rr = $urandom_range(0, 31);
    rc = $urandom_range(0, 15);
    case (mode)
      M_FRAMES: begin
        f = 1;
        case ($urandom_range(0, 2))
          0: begin rr = 1; rc = 4; end
          1: begin rr = m_row; rc = m_col; end
          default: begin rr = ROWS - 1; rc = 4; end
        endcase
      end
      M_SWEEP: begin
        rr = sweep_idx / COLS; rc = sweep_idx % COLS;
        sweep_idx = (sweep_idx + 1) % (ROWS * COLS);
      end
      M_NPULSE: n = 1;
      default: begin
        f = ($urandom_range(0, 1) == 1);
        if (m_phase == P_SPAWN)
          target = (mode == M_STACK) ? SPAWN_COL :
                   (($urandom_range(0, 4) == 0) ? int'($urandom_range(0, COLS - 1)) : lowest_col());
        if (m_phase == P_FALL) begin
          if (m_col < target && $urandom_range(0, 1) == 1) e = 1;
          else if (m_col > target && $urandom_range(0, 1) == 1) w = 1;
          else if (m_col == target && $urandom_range(0, 2) == 0) c = 1;
          else if ($urandom_range(0, 7) == 0) s = 1;
          else if ($urandom_range(0, 39) == 0) c = 1;
        end else if ($urandom_range(0, 7) == 0) begin
          {c, s, e, w} = 4'($urandom);
        end
        if ($urandom_range(0, 15) == 0) {c, s, e, w} = 4'($urandom);
        if (mode == M_PLAY && $urandom_range(0, 2999) == 0) n = 1;
        if (mode == M_PLAY && m_phase == P_OVER && $urandom_range(0, 19) == 0) n = 1;
        if ($urandom_range(0, 2) == 0) begin rr = m_row; rc = m_col; end
      end
    endcase
    i_frame_start = f; i_pls_n = n; i_pls_c = c; i_pls_s = s; i_pls_e = e; i_pls_w = w;
    i_rd_row = 5'(rr); i_rd_col = 4'(rc);
    x.rd = model_read(rr, rc);
    model_step(f, n, c, s, e, w);
    x.due = cyc + 1;
    x.busy = (m_phase != P_FALL) ? 1 : 0;
    x.over = (m_phase == P_OVER) ? 1 : 0;
    x.score = m_score;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    exp_t x;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      x = sb.pop_front();
      check("rd_cell", int'(o_rd_cell), x.rd);
      check("busy", int'(o_busy), x.busy);
      check("game_over", int'(o_game_over), x.over);
      check("score", int'(o_score), x.score);
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd"}, int'(o_rd_cell), 0);
    check({tag, "_busy"}, int'(o_busy), 1);
    check({tag, "_over"}, int'(o_game_over), 0);
    check({tag, "_score"}, int'(o_score), 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int guard;
    i_frame_start = 0; i_pls_w = 0; i_pls_e = 0; i_pls_s = 0; i_pls_c = 0; i_pls_n = 0;
    i_rd_row = 0; i_rd_col = 0;
    model_reset(1'b1);
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1;

    // gravity-only descent, then a full-board readback, then natural lock at the floor
    repeat (40) drive_cycle(M_FRAMES);
    repeat (200) drive_cycle(M_SWEEP);
    repeat (640) drive_cycle(M_FRAMES);

    // random gameplay with row clears
    repeat (25000) drive_cycle(M_PLAY);

    // stack the spawn column until the spawn is blocked, then restart
    guard = 0;
    while (m_phase != P_OVER && guard < 8000) begin
      drive_cycle(M_STACK);
      guard++;
    end
    check("over_reached", int'(o_game_over), 1);
    repeat (30) drive_cycle(M_STACK);
    drive_cycle(M_NPULSE);
    repeat (2) drive_cycle(M_SWEEP);
    check("restart_fall", int'(o_busy), 0);
    repeat (200) drive_cycle(M_SWEEP);

    // asynchronous reset while a row shift is in progress
    guard = 0;
    while (m_phase != P_SHIFT && guard < 20000) begin
      drive_cycle(M_PLAY);
      guard++;
    end
    check("shift_reached", (m_phase == P_SHIFT) ? 1 : 0, 1);
    sb.delete();
    i_frame_start = 0; i_pls_w = 0; i_pls_e = 0; i_pls_s = 0; i_pls_c = 0; i_pls_n = 0;
    #2 rst_n = 0;
    #1 check_reset_outputs("midshift_reset");
    @(posedge clk);
    #1 check_reset_outputs("held_reset");
    model_reset(1'b1);
    rst_n = 1;
    repeat (200) drive_cycle(M_SWEEP);
    repeat (3000) drive_cycle(M_PLAY);

    @(negedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
